// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in, serial-out shifter.
// The macro PISO_SHIFTER_PARITY_EN enables a trailing even-parity bit.
package piso_pkg;

  localparam int PISO_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } piso_state_e;

  // Even parity of a word; zero-extension does not change the result.
  function automatic logic parity_f(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/piso_bitcnt.sv
// Loadable down-counter tracking the remaining data bits of a frame.
// It saturates at zero and flags the last data bit.
module piso_bitcnt
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_WIDTH
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LOAD_VAL = CW'(WIDTH - 1);

  logic [CW-1:0] cnt;

  // Load on handshake, otherwise count down once per shifted bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/piso_shifter.sv
// Parallel-in, serial-out shifter emitting words MSB-first.
// Define PISO_SHIFTER_PARITY_EN to append an even-parity bit per frame.
module piso_shifter
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             done
);

  piso_state_e      state;
  logic [WIDTH-1:0] shreg;
  logic             zero;
  logic             last;
  logic             take;
`ifdef PISO_SHIFTER_PARITY_EN
  logic             par;
`endif

  piso_bitcnt #(
    .WIDTH(WIDTH)
  ) u_bitcnt (
    .clock(clock),
    .reset(reset),
    .load (take),
    .dec  (state == SHIFT),
    .zero (zero)
  );

  assign last = (state == SHIFT) && zero;
  assign take = load_valid && load_ready;

  // Ready decode: idle, or the final cycle of the current frame.
  always_comb begin
    load_ready = 1'b0;
    if (!reset) begin
      unique case (state)
        IDLE:    load_ready = 1'b1;
`ifdef PISO_SHIFTER_PARITY_EN
        SHIFT:   load_ready = 1'b0;
        PARITY:  load_ready = 1'b1;
`else
        SHIFT:   load_ready = last;
        PARITY:  load_ready = 1'b0;
`endif
        default: load_ready = 1'b0;
      endcase
    end
  end

  // Frame FSM and shift register; a handshake always starts a new frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
`ifdef PISO_SHIFTER_PARITY_EN
      par   <= 1'b0;
`endif
    end else if (take) begin
      state <= SHIFT;
      shreg <= load_data;
`ifdef PISO_SHIFTER_PARITY_EN
      par   <= parity_f(32'(load_data));
`endif
    end else begin
      unique case (state)
        IDLE: begin
          state <= IDLE;
        end
        SHIFT: begin
          shreg <= {shreg[WIDTH-2:0], 1'b0};
          if (zero) begin
`ifdef PISO_SHIFTER_PARITY_EN
            state <= PARITY;
`else
            state <= IDLE;
`endif
          end
        end
        PARITY: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign ser_valid = (state != IDLE);

  // Serial bit and end-of-frame decode from registered state.
  always_comb begin
    ser_out = 1'b0;
    done    = 1'b0;
    unique case (state)
      SHIFT: begin
        ser_out = shreg[WIDTH-1];
`ifndef PISO_SHIFTER_PARITY_EN
        done    = last;
`endif
      end
`ifdef PISO_SHIFTER_PARITY_EN
      PARITY: begin
        ser_out = par;
        done    = 1'b1;
      end
`endif
      default: begin
        ser_out = 1'b0;
        done    = 1'b0;
      end
    endcase
  end

endmodule
